wb_stage: RTL

//  Writeback stage: the register-file write side of the pipeline. It takes the retiring memory-stage record,

---
 rtl/riscv32i_pkg.sv | 88 ++++++++
 rtl/wb_load_align.sv | 54 +++++
 rtl/wb_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv32i_pkg.sv
// Shared RV32I definitions used by decode, execute, dataMem and writeback.
//  - Bit indices of the 64-bit one-hot Single_Instruction vector (INST_LB..INST_EBREAK).
//    Bits 40..63 are reserved and decode to no instruction class.
//  - Class masks built from those indices, used by the writeback select logic.
//  - Writeback FSM state type {WB_RUN, WB_HALTED}.
package riscv32i_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 64;

  // Loads
  localparam int INST_LB     = 0;
  localparam int INST_LH     = 1;
  localparam int INST_LW     = 2;
  localparam int INST_LBU    = 3;
  localparam int INST_LHU    = 4;
  // Stores
  localparam int INST_SB     = 5;
  localparam int INST_SH     = 6;
  localparam int INST_SW     = 7;
  // ALU immediate
  localparam int INST_ADDI   = 8;
  localparam int INST_SLTI   = 9;
  localparam int INST_SLTIU  = 10;
  localparam int INST_XORI   = 11;
  localparam int INST_ORI    = 12;
  localparam int INST_ANDI   = 13;
  localparam int INST_SLLI   = 14;
  localparam int INST_SRLI   = 15;
  localparam int INST_SRAI   = 16;
  // ALU register
  localparam int INST_ADD    = 17;
  localparam int INST_SUB    = 18;
  localparam int INST_SLL    = 19;
  localparam int INST_SLT    = 20;
  localparam int INST_SLTU   = 21;
  localparam int INST_XOR    = 22;
  localparam int INST_SRL    = 23;
  localparam int INST_SRA    = 24;
  localparam int INST_OR     = 25;
  localparam int INST_AND    = 26;
  // Branches
  localparam int INST_BEQ    = 27;
  localparam int INST_BNE    = 28;
  localparam int INST_BLT    = 29;
  localparam int INST_BGE    = 30;
  localparam int INST_BLTU   = 31;
  localparam int INST_BGEU   = 32;
  // Upper immediate, jumps, system
  localparam int INST_LUI    = 33;
  localparam int INST_AUIPC  = 34;
  localparam int INST_JAL    = 35;
  localparam int INST_JALR   = 36;
  localparam int INST_FENCE  = 37;
  localparam int INST_ECALL  = 38;
  localparam int INST_EBREAK = 39;

  // One-hot vector with only bit idx set.
  function automatic logic [INST_W-1:0] inst_mask(input int idx);
    return {{(INST_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  localparam logic [INST_W-1:0] LOAD_MASK =
      inst_mask(INST_LB) | inst_mask(INST_LH) | inst_mask(INST_LW) |
      inst_mask(INST_LBU) | inst_mask(INST_LHU);

  localparam logic [INST_W-1:0] JUMP_MASK =
      inst_mask(INST_JAL) | inst_mask(INST_JALR);

  // Classes whose writeback value is the execute result unchanged.
  localparam logic [INST_W-1:0] ALU_WB_MASK =
      inst_mask(INST_ADDI) | inst_mask(INST_SLTI) | inst_mask(INST_SLTIU) |
      inst_mask(INST_XORI) | inst_mask(INST_ORI)  | inst_mask(INST_ANDI)  |
      inst_mask(INST_SLLI) | inst_mask(INST_SRLI) | inst_mask(INST_SRAI)  |
      inst_mask(INST_ADD)  | inst_mask(INST_SUB)  | inst_mask(INST_SLL)   |
      inst_mask(INST_SLT)  | inst_mask(INST_SLTU) | inst_mask(INST_XOR)   |
      inst_mask(INST_SRL)  | inst_mask(INST_SRA)  | inst_mask(INST_OR)    |
      inst_mask(INST_AND)  | inst_mask(INST_LUI)  | inst_mask(INST_AUIPC);

  localparam logic [INST_W-1:0] HALT_MASK =
      inst_mask(INST_ECALL) | inst_mask(INST_EBREAK);

  typedef enum logic {
    WB_RUN     = 1'b0,
    WB_HALTED  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load formatter for the writeback stage.
// Selects the byte/halfword addressed by addr_i out of the raw memory word,
// sign-extends LB/LH, zero-extends LBU/LHU, passes LW through, and flags
// misaligned halfword/word accesses.
// Ports:
//  inst_i        in  64  one-hot instruction class
//  addr_i        in  2   low bits of the effective address
//  data_i        in  32  raw word read from data memory
//  data_o        out 32  formatted load value
//  is_load_o     out 1   record is any load class
//  misaligned_o  out 1   LH/LHU with addr[0]=1, or LW with addr[1:0]!=0
module wb_load_align
  import riscv32i_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  input  logic [1:0]        addr_i,
  input  logic [XLEN-1:0]   data_i,
  output logic [XLEN-1:0]   data_o,
  output logic              is_load_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    byte_sel = data_i[7:0];
    case (addr_i)
      2'd0: byte_sel = data_i[7:0];
      2'd1: byte_sel = data_i[15:8];
      2'd2: byte_sel = data_i[23:16];
      2'd3: byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
    half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

    data_o = data_i;
    if (inst_i[INST_LB])
      data_o = {{24{byte_sel[7]}}, byte_sel};
    else if (inst_i[INST_LBU])
      data_o = {24'd0, byte_sel};
    else if (inst_i[INST_LH])
      data_o = {{16{half_sel[15]}}, half_sel};
    else if (inst_i[INST_LHU])
      data_o = {16'd0, half_sel};
  end

  assign is_load_o    = |(inst_i & LOAD_MASK);
  assign misaligned_o = ((inst_i[INST_LH] | inst_i[INST_LHU]) & addr_i[0]) |
                        (inst_i[INST_LW] & (addr_i != 2'd0));

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: register-file write side of the pipeline.
// Registers the retiring memory-stage record (1-cycle latency), formats load
// data, selects the writeback value and drives the reg_file write port.
// Detects halt (ECALL/EBREAK), misaligned loads and illegal (all-zero) records.
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction
// counter on port instret_o.
// Ports:
//  clk, reset              clock, synchronous active-high reset
//  valid_i, stall_i        record valid / hold (stall wins)
//  pc_i, rd_i              PC and destination register of the record
//  Single_Instruction_i    one-hot instruction class
//  alu_result_i            execute result / effective address
//  load_data_i             raw data memory word
//  we_o, destReg_o, writeData_o   reg_file write port
//  retire_o, misalign_o, illegal_o 1-cycle event pulses
//  halted_o                sticky halt request
//  instret_o               retired count (WB_INSTRET_EN only)
module wb_stage
  import riscv32i_pkg::*;
#(
  parameter int N_param = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                stall_i,
  input  logic [N_param-1:0]  pc_i,
  input  logic [4:0]          rd_i,
  input  logic [INST_W-1:0]   Single_Instruction_i,
  input  logic [N_param-1:0]  alu_result_i,
  input  logic [N_param-1:0]  load_data_i,
  output logic                we_o,
  output logic [4:0]          destReg_o,
  output logic [N_param-1:0]  writeData_o,
  output logic                retire_o,
  output logic                misalign_o,
  output logic                illegal_o,
  output logic                halted_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]         instret_o
`endif
);

  wb_state_t          state, state_next;
  logic               accept;
  logic               illegal;
  logic               is_halt;
  logic               is_jump;
  logic               is_alu_wb;
  logic               is_load;
  logic               misaligned;
  logic               writes_rd;
  logic [N_param-1:0] load_value;
  logic [N_param-1:0] wb_value;
  logic               we_d;
  logic               retire_d;
  logic               misalign_d;
  logic               illegal_d;

  wb_load_align u_load_align (
    .inst_i       (Single_Instruction_i),
    .addr_i       (alu_result_i[1:0]),
    .data_i       (load_data_i),
    .data_o       (load_value),
    .is_load_o    (is_load),
    .misaligned_o (misaligned)
  );

  // Stall has priority over valid; nothing is consumed once halted.
  assign accept    = valid_i & ~stall_i & (state == WB_RUN);
  assign illegal   = (Single_Instruction_i == '0);
  assign is_halt   = |(Single_Instruction_i & HALT_MASK);
  assign is_jump   = |(Single_Instruction_i & JUMP_MASK);
  assign is_alu_wb = |(Single_Instruction_i & ALU_WB_MASK);
  assign writes_rd = is_load | is_jump | is_alu_wb;

  // Link address wraps naturally at 2^32.
  always_comb begin
    wb_value = alu_result_i;
    if (is_jump)
      wb_value = pc_i + N_param'(4);
    else if (is_load)
      wb_value = load_value;
  end

  assign we_d       = accept & writes_rd & (rd_i != 5'd0) & ~misaligned;
  assign retire_d   = accept & ~illegal;
  assign misalign_d = accept & is_load & misaligned;
  assign illegal_d  = accept & illegal;

  always_comb begin
    state_next = state;
    case (state)
      WB_RUN:    if (accept && (is_halt || illegal)) state_next = WB_HALTED;
      WB_HALTED: state_next = WB_HALTED;
      default:   state_next = WB_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WB_RUN;
      we_o        <= 1'b0;
      destReg_o   <= 5'd0;
      writeData_o <= '0;
      retire_o    <= 1'b0;
      misalign_o  <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      state      <= state_next;
      we_o       <= we_d;
      retire_o   <= retire_d;
      misalign_o <= misalign_d;
      illegal_o  <= illegal_d;
      if (accept) begin
        destReg_o   <= rd_i;
        writeData_o <= wb_value;
      end
    end
  end

  assign halted_o = (state == WB_HALTED);

`ifdef WB_INSTRET_EN
  // Counts in the same edge that raises retire_o; wraps at 2^64.
  always_ff @(posedge clk) begin
    if (reset)
      instret_o <= 64'd0;
    else if (retire_d)
      instret_o <= instret_o + 64'd1;
  end
`endif

endmodule
